seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 12 +
 rtl/div_sub_stage.sv | 18 +
 rtl/seq_divider.sv | 122 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared FSM state type and default width for the sequential divider
package div_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_sub_stage.sv
// rtl/div_sub_stage.sv - one restoring-division step: trial subtract of the divisor and restore
module div_sub_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] pr,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_nxt,
  output logic             qbit
);

  logic [WIDTH:0] diff;

  // The kept remainder is always below the divisor, so a successful trial fits in WIDTH+1 bits.
  assign qbit    = (pr >= {2'b00, dvs});
  assign diff    = pr[WIDTH:0] - {1'b0, dvs};
  assign rem_nxt = qbit ? diff : pr[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - radix-2 restoring sequential divider, one quotient bit per cycle
// Optional feature: SEQ_DIV_ZERO_DETECT_EN short-circuits divide-by-zero and raises dbz.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t     state, state_nxt;
  logic           load, step, finish;
  logic [CW-1:0]  cnt;
  logic [WIDTH:0] rem, rem_nxt;
  logic [WIDTH-1:0] dq, dvs;
  logic           qbit;

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .pr      ({rem, dq[WIDTH-1]}),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
`ifdef SEQ_DIV_ZERO_DETECT_EN
          state_nxt = (divisor == '0) ? DONE : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // dq starts as the dividend and fills with quotient bits as the dividend shifts out.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      rem       <= '0;
      dq        <= '0;
      dvs       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= finish;
      if (load) begin
        cnt  <= '0;
        rem  <= '0;
        dq   <= dividend;
        dvs  <= divisor;
        busy <= 1'b1;
`ifdef SEQ_DIV_ZERO_DETECT_EN
        if (divisor == '0) begin
          dq  <= '1;
          rem <= {1'b0, dividend};
        end
`endif
      end else if (step) begin
        cnt <= cnt + 1'b1;
        rem <= rem_nxt;
        dq  <= {dq[WIDTH-2:0], qbit};
      end else if (finish) begin
        busy      <= 1'b0;
        quotient  <= dq;
        remainder <= rem[WIDTH-1:0];
      end
    end
  end

`ifdef SEQ_DIV_ZERO_DETECT_EN
  logic dbz_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      dbz_pend <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      if (load)   dbz_pend <= (divisor == '0);
      if (finish) dbz      <= dbz_pend;
    end
  end
`else
  assign dbz = 1'b0;
`endif

endmodule
